// File: rtl/scan_capture.sv
`default_nettype none
// ============================================================================
//  Module      : scan_capture
//  Description : Raster scanner that presents (x,y) coordinates to a pixel
//                drawer and captures its active-low write strobes into a
//                linear framebuffer address space. A LAT-deep address delay
//                line aligns each captured pixel with the coordinate that
//                produced it.
//                Optional feature macro: SCAN_CAPTURE_STATS_EN adds the
//                per-frame write counters wr_count / last_count.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_capture #(
  parameter int H_ACTIVE = 240,
  parameter int V_ACTIVE = 240,
  parameter int LAT      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [8:0]  x,
  output logic [8:0]  y,
  input  logic [15:0] dq,
  input  logic        w_en,
  output logic [16:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
`ifdef SCAN_CAPTURE_STATS_EN
  output logic [16:0] wr_count,
  output logic [16:0] last_count,
`endif
  output logic        frame_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  // Flush counter runs 0..LAT-1; keep it at least one bit wide for LAT=1.
  localparam int              FC_W     = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [FC_W-1:0] FC_LAST  = FC_W'(LAT - 1);
  localparam logic [8:0]      X_LAST   = 9'(H_ACTIVE - 1);
  localparam logic [8:0]      Y_LAST   = 9'(V_ACTIVE - 1);
  localparam logic [16:0]     H_STRIDE = 17'(H_ACTIVE);

  logic [1:0]            state_q, state_d;
  logic [8:0]            x_q, x_d;
  logic [8:0]            y_q, y_d;
  logic [FC_W-1:0]       flush_cnt_q, flush_cnt_d;
  logic [LAT-1:0]        dl_valid_q, dl_valid_d;
  logic [LAT-1:0][16:0]  dl_addr_q, dl_addr_d;
  logic [16:0]           lin_addr;

  // Linear address of the coordinate currently presented (single constant multiply).
  assign lin_addr = (17'(y_q) * H_STRIDE) + 17'(x_q);

  // Scan sequencing: idle at origin, raster walk, then drain the delay line.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      S_IDLE: begin
        x_d = '0;
        y_d = '0;
        if (en) begin
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        // en is deliberately not consulted here: a started frame always completes.
        if (x_q == X_LAST) begin
          x_d = '0;
          if (y_q == Y_LAST) begin
            y_d         = '0;
            flush_cnt_d = '0;
            state_d     = S_FLUSH;
          end else begin
            y_d = y_q + 9'd1;
          end
        end else begin
          x_d = x_q + 9'd1;
        end
      end
      S_FLUSH: begin
        x_d = '0;
        y_d = '0;
        if (flush_cnt_q == FC_LAST) begin
          flush_cnt_d = '0;
          state_d     = en ? S_SCAN : S_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q + FC_W'(1);
        end
      end
      default: begin
        state_d     = S_IDLE;
        x_d         = '0;
        y_d         = '0;
        flush_cnt_d = '0;
      end
    endcase
  end

  // Address delay line: stage 0 takes the presented coordinate, last stage faces the drawer's reply.
  always_comb begin
    dl_valid_d    = dl_valid_q;
    dl_addr_d     = dl_addr_q;
    dl_valid_d[0] = (state_q == S_SCAN);
    dl_addr_d[0]  = lin_addr;
    for (int i = 1; i < LAT; i++) begin
      dl_valid_d[i] = dl_valid_q[i-1];
      dl_addr_d[i]  = dl_addr_q[i-1];
    end
  end

  // State registers with synchronous reset; clearing valid bits suppresses any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      flush_cnt_q <= '0;
      dl_valid_q  <= '0;
      dl_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      flush_cnt_q <= flush_cnt_d;
      dl_valid_q  <= dl_valid_d;
      dl_addr_q   <= dl_addr_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  // A strobe is only honoured when the delay line holds a real scan coordinate,
  // which also keeps undefined dq from ever reaching the framebuffer.
  assign mem_we     = dl_valid_q[LAT-1] & ~w_en;
  assign mem_addr   = dl_addr_q[LAT-1];
  assign mem_wdata  = dq;
  assign frame_done = (state_q == S_FLUSH) && (flush_cnt_q == FC_LAST);

`ifdef SCAN_CAPTURE_STATS_EN
  logic [16:0] wr_count_q, wr_count_d;
  logic [16:0] last_count_q, last_count_d;

  // Per-frame write tally; the write coinciding with frame_done belongs to the closing frame.
  always_comb begin
    wr_count_d   = wr_count_q + {16'd0, mem_we};
    last_count_d = last_count_q;
    if (frame_done) begin
      last_count_d = wr_count_d;
      wr_count_d   = '0;
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_q   <= '0;
      last_count_q <= '0;
    end else begin
      wr_count_q   <= wr_count_d;
      last_count_q <= last_count_d;
    end
  end

  assign wr_count   = wr_count_q;
  assign last_count = last_count_q;
`endif

endmodule
`default_nettype wire

// File: doc/scan_capture.md
SCAN_CAPTURE -- requirements
Module: scan_capture

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 240, meaning visible columns scanned per line (x range 0..H_ACTIVE-1, max 511).
REQ-002 The block SHALL have parameter V_ACTIVE, default 240, meaning visible lines per frame (y range 0..V_ACTIVE-1, max 511).
REQ-003 The block SHALL have parameter LAT, default 1, meaning cycles from x/y presentation to the matching dq/w_en.
REQ-004 The block SHALL have port clk, input, 1, meaning the single system clock.
REQ-005 The block SHALL have port rst, input, 1, meaning reset; synchronous, active-high.
REQ-006 The block SHALL have port en, input, 1, meaning scanning allowed.
REQ-007 The block SHALL have port x, output, 9, meaning current scan column.
REQ-008 The block SHALL have port y, output, 9, meaning current scan line.
REQ-009 The block SHALL have port dq, input, 16, meaning pixel data from the drawer (RGB555, bit15 ignored).
REQ-010 The block SHALL have port w_en, input, 1, meaning active-low write strobe from the drawer.
REQ-011 The block SHALL have port mem_addr, output, 17, meaning framebuffer address y*H_ACTIVE+x of the captured pixel.
REQ-012 The block SHALL have port mem_wdata, output, 16, meaning captured pixel.
REQ-013 The block SHALL have port mem_we, output, 1, meaning one-cycle framebuffer write pulse.
REQ-014 The block SHALL have port frame_done, output, 1, meaning one-cycle pulse after the last pixel of a frame has drained.

Function
REQ-015 The FSM SHALL have states IDLE, SCAN, FLUSH.
REQ-016 In IDLE, x and y SHALL both be 0, and the FSM SHALL go to SCAN on the first cycle en=1.
REQ-017 In SCAN, x SHALL increment by 1 every cycle.
REQ-018 In SCAN, when x=H_ACTIVE-1, x SHALL wrap to 0 and y SHALL increment.
REQ-019 In SCAN, when x=H_ACTIVE-1 and y=V_ACTIVE-1, the FSM SHALL enter FLUSH with x=y=0.
REQ-020 Each presented (x,y) SHALL be pushed into a LAT-deep address delay line, with a valid bit set only for coordinates issued in SCAN.
REQ-021 mem_we SHALL be 1 in cycle N+LAT iff the delay-line output is valid and w_en=0 in that cycle.
REQ-022 mem_wdata SHALL equal dq in that same cycle, combinationally passed through.
REQ-023 mem_addr SHALL be the delayed linear address in that same cycle, computed without multiplier inference beyond one constant multiply.
REQ-024 w_en=0 while the delay-line output is invalid SHALL be ignored, with no write.
REQ-025 FLUSH SHALL last exactly LAT cycles, during which x/y are held at 0 and the delay line drains.
REQ-026 frame_done SHALL pulse on the last FLUSH cycle.
REQ-027 After FLUSH, the FSM SHALL return to SCAN if en=1, else to IDLE.
REQ-028 en dropping mid-frame SHALL NOT stop the frame, which completes.
REQ-029 dq values of z/x SHALL NOT be written, since they are gated by w_en.

Reset
REQ-030 rst=1 on a rising clk edge SHALL force IDLE, x=0, y=0, all delay-line valid bits 0, mem_we=0, and frame_done=0.
REQ-031 Reset mid-frame or mid-FLUSH SHALL abort immediately, with no write or frame_done in the following cycle.

Configuration
REQ-032 With macro SCAN_CAPTURE_STATS_EN defined, the block SHALL add output wr_count[16:0], counting mem_we pulses in the current frame.
REQ-033 With SCAN_CAPTURE_STATS_EN defined, wr_count SHALL be latched to output last_count[16:0] and cleared on frame_done; both SHALL reset to 0.
REQ-034 Without SCAN_CAPTURE_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-035 Scenario: reset then en=1 with H=V=4, LAT=1 -> x sequence 0,1,2,3,0… and y incrementing; FLUSH 1 cycle; frame_done at cycle 17 after en.
REQ-036 Scenario: drawer model holding w_en=0 always with dq=16'h7c00 -> 16 writes, addresses 0..15 in order, each one cycle after its x/y.
REQ-037 Scenario: w_en=0 only when delayed (x,y)=(2,1) -> exactly one mem_we, mem_addr=6, mem_wdata=dq.
REQ-038 Scenario: rst asserted at (x,y)=(1,2) -> next cycle IDLE, x=y=0, mem_we=0, no frame_done.
REQ-039 Scenario: en dropped at y=1 -> frame completes, frame_done pulses, FSM returns to IDLE.
REQ-040 Scenario: with SCAN_CAPTURE_STATS_EN, write 5 pixels -> last_count=5 after frame_done and wr_count=0.
